// File: rtl/axi4_slave_read_addr_queue.sv
// rtl/axi4_slave_read_addr_queue.sv - AXI4 slave AR channel request queue with burst validation
// Optional feature macro: AXI_AR_4K_CHECK_EN (flags INCR bursts that cross a 4 KB boundary).
module axi4_slave_read_addr_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arvalid,
  output logic                        arready,
  input  logic [ADDR_WIDTH-1:0]       araddr,
  input  logic [ID_WIDTH-1:0]         arid,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [ADDR_WIDTH-1:0]       latched_araddr,
  output logic [ID_WIDTH-1:0]         latched_arid,
  output logic [7:0]                  latched_arlen,
  output logic [2:0]                  latched_arsize,
  output logic [1:0]                  latched_arburst,
  output logic                        req_err,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SIZE_MAX = $clog2(DATA_WIDTH / 8);

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [2:0]    SIZE_LIM = 3'(SIZE_MAX);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] BURST_RSVD = 2'b11;

  // Entry storage, one array per field
  logic [ADDR_WIDTH-1:0] addr_q  [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]   id_q    [FIFO_DEPTH];
  logic [7:0]            len_q   [FIFO_DEPTH];
  logic [2:0]            size_q  [FIFO_DEPTH];
  logic [1:0]            burst_q [FIFO_DEPTH];
  logic                  err_q   [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic          in_err;
  logic          size_err;
  logic          burst_err;
  logic          wrap_err;
  logic          cross_err;
  logic [PW-1:0] head_idx;

  // Handshake qualifiers; arready looks only at registered state, never at arvalid
  always_comb begin
    arready   = (count_q != FULL_CNT) && !rst;
    req_valid = (count_q != '0) && !rst;
    push      = arvalid && arready;
    pop       = req_valid && req_ready;
  end

  // Validation of the incoming AR attributes, evaluated once at push time
  always_comb begin
    size_err  = (arsize > SIZE_LIM);
    burst_err = (arburst == BURST_RSVD);
    wrap_err  = (arburst == BURST_WRAP) &&
                !((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15));
`ifdef AXI_AR_4K_CHECK_EN
    // 21 bits hold 4095 + 256*128 without overflow
    cross_err = (arburst == BURST_INCR) &&
                (({9'd0, araddr[11:0]} + ((21'(arlen) + 21'd1) << arsize)) > 21'd4096);
`else
    cross_err = 1'b0;
`endif
    in_err = size_err || burst_err || wrap_err || cross_err;
  end

  // Next-state for pointers and count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers; reset wipes every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i]  <= '0;
        id_q[i]    <= '0;
        len_q[i]   <= '0;
        size_q[i]  <= '0;
        burst_q[i] <= '0;
        err_q[i]   <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        addr_q[wr_ptr_q]  <= araddr;
        id_q[wr_ptr_q]    <= arid;
        len_q[wr_ptr_q]   <= arlen;
        size_q[wr_ptr_q]  <= arsize;
        burst_q[wr_ptr_q] <= arburst;
        err_q[wr_ptr_q]   <= in_err;
      end
    end
  end

  // Head view: the slot behind rd_ptr is the last one read, and nothing
  // writes it while the queue is empty, so it doubles as the hold value
  always_comb begin
    head_idx = (count_q != '0) ? rd_ptr_q : (rd_ptr_q - PTR_ONE);
    if (rst) begin
      latched_araddr  = '0;
      latched_arid    = '0;
      latched_arlen   = '0;
      latched_arsize  = '0;
      latched_arburst = '0;
      req_err         = 1'b0;
      occupancy       = '0;
    end else begin
      latched_araddr  = addr_q[head_idx];
      latched_arid    = id_q[head_idx];
      latched_arlen   = len_q[head_idx];
      latched_arsize  = size_q[head_idx];
      latched_arburst = burst_q[head_idx];
      req_err         = err_q[head_idx];
      occupancy       = count_q;
    end
  end

endmodule

// File: tb/tb_axi4_slave_read_addr_queue.sv
// tb/tb_axi4_slave_read_addr_queue.sv - scoreboard bench for axi4_slave_read_addr_queue
module tb_axi4_slave_read_addr_queue;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        err;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] latched_araddr;
  logic [3:0]  latched_arid;
  logic [7:0]  latched_arlen;
  logic [2:0]  latched_arsize;
  logic [1:0]  latched_arburst;
  logic        req_err;
  logic [1:0]  occupancy;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t sb_q[$];
  ent_t last_rd = '0;
  logic rand_done;

  axi4_slave_read_addr_queue #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .req_valid(req_valid), .req_ready(req_ready),
    .latched_araddr(latched_araddr), .latched_arid(latched_arid),
    .latched_arlen(latched_arlen), .latched_arsize(latched_arsize),
    .latched_arburst(latched_arburst), .req_err(req_err), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [7:0] l,
                                     input logic [2:0] s, input logic [1:0] b);
    logic e;
    e = (s > 3'd2) || (b == 2'b11) ||
        ((b == 2'b10) && !((l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15)));
`ifdef AXI_AR_4K_CHECK_EN
    if ((b == 2'b01) && (({9'd0, a[11:0]} + ({13'd0, l} + 21'd1) * (21'd1 << s)) > 21'd4096))
      e = 1'b1;
`endif
    return e;
  endfunction

  // Scoreboard: compare DUT state against the model queue, then apply this cycle's handshakes
  always @(negedge clk) begin
    ent_t head;
    logic exp_rdy;
    if (rst) begin
      check_eq("rst_arready", {63'd0, arready}, 64'd0);
      check_eq("rst_req_valid", {63'd0, req_valid}, 64'd0);
      check_eq("rst_req_err", {63'd0, req_err}, 64'd0);
      check_eq("rst_occupancy", {62'd0, occupancy}, 64'd0);
      check_eq("rst_latched_araddr", {32'd0, latched_araddr}, 64'd0);
      check_eq("rst_latched_misc", {47'd0, latched_arid, latched_arlen, latched_arsize, latched_arburst}, 64'd0);
      sb_q.delete();
      last_rd = '0;
    end else begin
      exp_rdy = (sb_q.size() != DEPTH);
      check_eq("occupancy", {62'd0, occupancy}, 64'(sb_q.size()));
      check_eq("req_valid", {63'd0, req_valid}, {63'd0, sb_q.size() != 0});
      check_eq("arready", {63'd0, arready}, {63'd0, exp_rdy});
      head = (sb_q.size() != 0) ? sb_q[0] : last_rd;
      check_eq("head_araddr", {32'd0, latched_araddr}, {32'd0, head.addr});
      check_eq("head_arid", {60'd0, latched_arid}, {60'd0, head.id});
      check_eq("head_arlen", {56'd0, latched_arlen}, {56'd0, head.len});
      check_eq("head_arsize", {61'd0, latched_arsize}, {61'd0, head.size});
      check_eq("head_arburst", {62'd0, latched_arburst}, {62'd0, head.burst});
      check_eq("head_req_err", {63'd0, req_err}, {63'd0, head.err});
      if (req_ready && sb_q.size() != 0) last_rd = sb_q.pop_front();
      if (arvalid && exp_rdy)
        sb_q.push_back('{araddr, arid, arlen, arsize, arburst,
                         model_err(araddr, arlen, arsize, arburst)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    logic ok;
    araddr = a; arid = id; arlen = l; arsize = s; arburst = b;
    arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = arready;
      tick();
    end
    arvalid = 1'b0;
    check_eq("ar_accept_in_time", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;

    // single accept, then one pop
    send_ar(32'h100, 4'd3, 8'd7, 3'd2, 2'b01);
    tick();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    tick();

    // full / backpressure with ordering 0,1,2
    send_ar(32'h200, 4'd0, 8'd0, 3'd2, 2'b01);
    send_ar(32'h300, 4'd1, 8'd1, 3'd1, 2'b00);
    fork
      send_ar(32'h400, 4'd2, 8'd3, 3'd0, 2'b10);
      begin
        repeat (2) tick();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
      end
    join
    tick();
    req_ready = 1'b1; repeat (4) tick(); req_ready = 1'b0;

    // simultaneous push/pop at occupancy 1
    send_ar(32'h500, 4'd5, 8'd1, 3'd2, 2'b01);
    req_ready = 1'b1;
    send_ar(32'h600, 4'd6, 8'd3, 3'd2, 2'b01);
    req_ready = 1'b0;
    tick();
    req_ready = 1'b1; repeat (3) tick(); req_ready = 1'b0;

    // validation errors interleaved with good requests
    req_ready = 1'b1;
    send_ar(32'h700, 4'd7, 8'd5, 3'd2, 2'b10);
    send_ar(32'h710, 4'd8, 8'd0, 3'd2, 2'b11);
    send_ar(32'h720, 4'd9, 8'd0, 3'd3, 2'b01);
    send_ar(32'h730, 4'd10, 8'd15, 3'd2, 2'b10);
    // 4 KB boundary: crossing and exactly touching
    send_ar(32'hFF0, 4'd11, 8'd7, 3'd2, 2'b01);
    send_ar(32'h1FE0, 4'd12, 8'd7, 3'd2, 2'b01);
    send_ar(32'h2FF0, 4'd13, 8'd7, 3'd2, 2'b00);
    repeat (4) tick();
    req_ready = 1'b0;

    // reset mid-operation with two queued
    send_ar(32'h800, 4'd1, 8'd0, 3'd0, 2'b01);
    send_ar(32'h900, 4'd2, 8'd0, 3'd0, 2'b01);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (2) tick();

    // random traffic with random downstream readiness
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++)
          send_ar($urandom, 4'($urandom), 8'($urandom_range(0, 16)),
                  3'($urandom_range(0, 3)), 2'($urandom));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          req_ready = 1'($urandom);
          tick();
        end
      end
    join
    req_ready = 1'b1; repeat (4) tick(); req_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
